// File: rtl/exc_sequencer_pkg.sv
// Shared types and constants for the exception sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, pc_sel and cause encodings, exception vector addresses,
// and a helper that maps a cause to its vector pc_sel code.
package exc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_VECTOR = 3'd2,
    ST_KERNEL = 3'd3,
    ST_RETURN = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PCSEL_NORMAL = 2'b00,
    PCSEL_EPC    = 2'b01,
    PCSEL_IRQ    = 2'b10,
    PCSEL_UNDEF  = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_IRQ   = 2'b01,
    CAUSE_UNDEF = 2'b10
  } cause_e;

  // Fetch addresses selected by PCSEL_IRQ / PCSEL_UNDEF in the PC mux.
  localparam logic [31:0] IRQ_VECTOR   = 32'h8000_0004;
  localparam logic [31:0] UNDEF_VECTOR = 32'h8000_0008;

  function automatic pc_sel_e vector_sel(input cause_e c);
    return (c == CAUSE_IRQ) ? PCSEL_IRQ : PCSEL_UNDEF;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a level signal entering the clk domain.
// Latency: 2 clk edges from d_i to q_o.
// Backpressure: none, free-running.
// Ports: clk/rst (async active-high), d_i asynchronous level in, q_o synchronised level out.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/exc_sequencer.sv
// Exception sequencer: accepts IRQ / undefined-instruction events at ID, drains MEM,
// vectors fetch, runs the handler in kernel mode and returns via epc.
// Latency: acceptance to vector = 2 cycles + mem_busy cycles seen in DRAIN.
// Backpressure: holds in DRAIN while mem_busy; acceptance deferred by br_flush_ex.
// Ports: clk/reset; irq_in (async), undef_in, id_valid, id_pc, br_flush_ex, mem_busy,
// kret_in in; kernel, epc, cause, pc_sel, stall_pc, flush_id, flush_if, exc_count out.
module exc_sequencer
  import exc_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        irq_in,
  input  logic        undef_in,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic        br_flush_ex,
  input  logic        mem_busy,
  input  logic        kret_in,
  output logic        kernel,
  output logic [31:0] epc,
  output logic [1:0]  cause,
  output logic [1:0]  pc_sel,
  output logic        stall_pc,
  output logic        flush_id,
  output logic        flush_if,
  output logic [15:0] exc_count
);

  logic        irq_sync;

  state_e      state_q, state_d;
  logic        irq_pend_q, irq_pend_d;
  logic        kernel_q, kernel_d;
  logic [31:0] epc_q, epc_d;
  cause_e      cause_q, cause_d;
  logic [15:0] exc_count_q, exc_count_d;
  logic        accept;

  sync2 u_irq_sync (
    .clk (clk),
    .rst (reset),
    .d_i (irq_in),
    .q_o (irq_sync)
  );

  // Events are only taken against a real instruction that is not being squashed
  // by a branch; a squashed slot would otherwise save a wrong-path PC in epc.
  always_comb begin
    accept = (state_q == ST_RUN) & id_valid & ~br_flush_ex & (irq_pend_q | undef_in);
  end

  always_comb begin
    state_d     = state_q;
    kernel_d    = kernel_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    exc_count_d = exc_count_q;
    // Pending IRQ is sticky: it survives KERNEL and RETURN until accepted.
    irq_pend_d  = irq_pend_q | irq_sync;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          state_d     = ST_DRAIN;
          exc_count_d = exc_count_q + 16'd1;
          if (irq_pend_q) begin
            // IRQ wins; the interrupted instruction re-executes on return.
            epc_d      = id_pc;
            cause_d    = CAUSE_IRQ;
            irq_pend_d = 1'b0;
          end else begin
            // Undef skips the faulting instruction on return.
            epc_d   = id_pc + 32'd4;
            cause_d = CAUSE_UNDEF;
          end
        end
      end
      ST_DRAIN: begin
        if (!mem_busy) begin
          state_d = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        state_d  = ST_KERNEL;
        kernel_d = 1'b1;
      end
      ST_KERNEL: begin
        if (kret_in) begin
          state_d  = ST_RETURN;
          kernel_d = 1'b0;
          cause_d  = CAUSE_NONE;
        end
      end
      ST_RETURN: begin
        // One mandatory RUN-side cycle with no acceptance so the returned-to
        // instruction always makes progress before the next event.
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_KERNEL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_KERNEL;
      irq_pend_q  <= 1'b0;
      kernel_q    <= 1'b1;
      epc_q       <= 32'd0;
      cause_q     <= CAUSE_NONE;
      exc_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      irq_pend_q  <= irq_pend_d;
      kernel_q    <= kernel_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      exc_count_q <= exc_count_d;
    end
  end

  // Pipeline controls are decoded from the state; the acceptance and kret
  // cycles need them in the same cycle, so they are not registered.
  always_comb begin
    pc_sel   = PCSEL_NORMAL;
    stall_pc = 1'b0;
    flush_id = 1'b0;
    flush_if = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          stall_pc = 1'b1;
          flush_id = 1'b1;
        end
      end
      ST_DRAIN: begin
        stall_pc = 1'b1;
        flush_id = 1'b1;
      end
      ST_VECTOR: begin
        pc_sel   = vector_sel(cause_q);
        flush_if = 1'b1;
        flush_id = 1'b1;
      end
      ST_KERNEL: begin
        if (kret_in) begin
          pc_sel   = PCSEL_EPC;
          flush_if = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign kernel    = kernel_q;
  assign epc       = epc_q;
  assign cause     = cause_q;
  assign exc_count = exc_count_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Self-checking bench for exc_sequencer: directed scenarios then randomized exceptions.
// Expected values come from transaction-level arithmetic (epc, cause, count, latency).
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_in, undef_in, id_valid, br_flush_ex, mem_busy, kret_in;
  logic [31:0] id_pc;
  logic        kernel;
  logic [31:0] epc;
  logic [1:0]  cause, pc_sel;
  logic        stall_pc, flush_id, flush_if;
  logic [15:0] exc_count;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count = 16'd0;

  always #5 clk = ~clk;

  exc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .undef_in    (undef_in),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .br_flush_ex (br_flush_ex),
    .mem_busy    (mem_busy),
    .kret_in     (kret_in),
    .kernel      (kernel),
    .epc         (epc),
    .cause       (cause),
    .pc_sel      (pc_sel),
    .stall_pc    (stall_pc),
    .flush_id    (flush_id),
    .flush_if    (flush_if),
    .exc_count   (exc_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    irq_in = 0; undef_in = 0; id_valid = 0; br_flush_ex = 0; mem_busy = 0; kret_in = 0;
  endtask

  // One-cycle irq_in pulse; after 4 edges it has passed the synchroniser and is latched.
  task automatic pend_irq();
    irq_in = 1'b1;
    cyc();
    irq_in = 1'b0;
    repeat (3) cyc();
  endtask

  // Starts in RUN right after a clock edge; ends in KERNEL.
  task automatic run_exception(input bit is_irq, input logic [31:0] pc, input int busy,
                               input int defer, input bit also_undef, input string tag);
    logic [31:0] exp_epc;
    logic [1:0]  exp_cause, exp_sel;
    int          lat, stalls;
    exp_epc   = is_irq ? pc : pc + 32'd4;
    exp_cause = is_irq ? 2'b01 : 2'b10;
    exp_sel   = is_irq ? 2'b10 : 2'b11;

    id_valid = 1; id_pc = pc; undef_in = is_irq ? also_undef : 1'b1;
    br_flush_ex = 1;
    for (int i = 0; i < defer; i++) begin
      #1;
      chk({tag, "/defer_stall"}, stall_pc, 0);
      cyc();
      chk({tag, "/defer_count"}, exc_count, exp_count);
    end
    br_flush_ex = 0; mem_busy = (busy > 0);
    #1;
    chk({tag, "/accept_stall"}, stall_pc, 1);
    chk({tag, "/accept_flush_id"}, flush_id, 1);
    exp_count = exp_count + 16'd1;

    lat = -1; stalls = 1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      id_valid = 0; undef_in = 0; mem_busy = (n <= busy);
      #1;
      if (pc_sel != 2'b00) begin
        lat = n;
        break;
      end
      if (stall_pc) stalls++;
    end
    chk({tag, "/latency"}, lat, 2 + busy);
    chk({tag, "/stall_cycles"}, stalls, 2 + busy);
    chk({tag, "/vec_pc_sel"}, pc_sel, exp_sel);
    chk({tag, "/vec_flush_if"}, flush_if, 1);
    chk({tag, "/epc"}, epc, exp_epc);
    chk({tag, "/cause"}, cause, exp_cause);
    chk({tag, "/exc_count"}, exc_count, exp_count);
    mem_busy = 0;
    cyc();
    chk({tag, "/kernel"}, kernel, 1);
    chk({tag, "/kernel_pc_sel"}, pc_sel, 0);
  endtask

  // Starts in KERNEL; ends in RUN right after a clock edge.
  task automatic do_return(input string tag);
    kret_in = 1;
    #1;
    chk({tag, "/kret_pc_sel"}, pc_sel, 2'b01);
    chk({tag, "/kret_flush_if"}, flush_if, 1);
    cyc();
    kret_in = 0;
    #1;
    chk({tag, "/ret_kernel"}, kernel, 0);
    chk({tag, "/ret_cause"}, cause, 0);
    chk({tag, "/ret_stall"}, stall_pc, 0);
    cyc();
  endtask

  initial begin
    idle_inputs();
    id_pc = 32'd0;
    reset = 1;
    repeat (2) cyc();
    chk("rst/kernel", kernel, 1);
    chk("rst/epc", epc, 0);
    chk("rst/cause", cause, 0);
    chk("rst/exc_count", exc_count, 0);
    chk("rst/pc_sel", pc_sel, 0);
    chk("rst/stall", stall_pc, 0);
    chk("rst/flush_id", flush_id, 0);
    chk("rst/flush_if", flush_if, 0);
    reset = 0;
    cyc();

    // Leave reset-time KERNEL via kret.
    do_return("boot");
    id_valid = 1; id_pc = 32'h0040_0000;
    #1;
    chk("run_idle/pc_sel", pc_sel, 0);
    chk("run_idle/stall", stall_pc, 0);
    chk("run_idle/flush_id", flush_id, 0);
    id_valid = 0;
    cyc();

    run_exception(0, 32'h0040_0010, 0, 0, 0, "undef");
    do_return("undef");

    pend_irq();
    run_exception(1, 32'h0040_0020, 2, 0, 0, "irq_drain");
    do_return("irq_drain");

    pend_irq();
    run_exception(1, 32'h0040_0030, 0, 1, 1, "prio_squash");
    do_return("prio_squash");

    // IRQ latched during KERNEL is ignored there, survives RETURN, taken in RUN.
    run_exception(0, 32'h0040_0040, 0, 0, 0, "kern_enter");
    id_valid = 1; undef_in = 1;
    pend_irq();
    chk("kern_ignore/stall", stall_pc, 0);
    chk("kern_ignore/count", exc_count, exp_count);
    kret_in = 1;
    #1;
    chk("simul/kret_pc_sel", pc_sel, 2'b01);
    cyc();
    kret_in = 0; undef_in = 0;
    #1;
    chk("simul/ret_stall", stall_pc, 0);
    chk("simul/ret_kernel", kernel, 0);
    cyc();
    id_valid = 0;
    #1;
    chk("simul/run_novalid_stall", stall_pc, 0);
    cyc();
    run_exception(1, 32'h0040_0050, 1, 0, 0, "simul");
    do_return("simul");

    // Reset in the middle of DRAIN: no vector may follow.
    id_valid = 1; undef_in = 1; id_pc = 32'h0040_0060; mem_busy = 1;
    cyc();
    id_valid = 0; undef_in = 0;
    #1;
    chk("rst_drain/stall", stall_pc, 1);
    reset = 1;
    #1;
    exp_count = 16'd0;
    chk("rst_drain/kernel", kernel, 1);
    chk("rst_drain/count", exc_count, exp_count);
    chk("rst_drain/epc", epc, 0);
    cyc();
    reset = 0; mem_busy = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_drain/no_vector", pc_sel, 0);
      cyc();
    end
    do_return("rst_drain");

    // Randomized exceptions.
    for (int k = 0; k < 12; k++) begin
      bit          r_irq;
      logic [31:0] r_pc;
      r_irq = 1'($urandom_range(0, 1));
      r_pc  = $urandom;
      if (r_irq) pend_irq();
      run_exception(r_irq, r_pc, $urandom_range(0, 3), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
      do_return($sformatf("rnd%0d", k));
    end

    // Counter and epc wrap.
    force dut.exc_count_q = 16'hFFFF;
    #1;
    release dut.exc_count_q;
    exp_count = 16'hFFFF;
    cyc();
    run_exception(0, 32'hFFFF_FFFC, 0, 0, 0, "wrap");
    do_return("wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
